// File: rtl/gpu_cmd_parser.sv
// rtl/gpu_cmd_parser.sv - command FIFO plus packet parser feeding the rasteriser
// Draw/clear/end-of-frame packets are assembled into one wide command word.
module gpu_cmd_parser #(
  parameter int FIFO_DEPTH = 16,
  parameter int NUM_VERTS  = 3,
  parameter int COORD_W    = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [31:0]                   fifo_write_data,
  input  logic                          fifo_write,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic [3:0]                    cmd_opcode,
  output logic [7:0]                    cmd_texnum,
  output logic [NUM_VERTS*32-1:0]       cmd_verts,
  output logic [31:0]                   cmd_color,
  output logic                          overflow,
  output logic                          bad_opcode
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  if (FIFO_DEPTH < 4 || (1 << AW) != FIFO_DEPTH || NUM_VERTS < 1 || NUM_VERTS > 8 ||
      COORD_W < 1 || 2 * COORD_W > 32) begin : g_bad_params
    $error("gpu_cmd_parser: unsupported parameter combination");
  end

  typedef enum logic [1:0] {IDLE, ARGS, PRESENT} state_t;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   head;
  logic          empty, pop, push;

  state_t                  state, state_n;
  logic [2:0]              idx, idx_n, last, last_n;
  logic [3:0]              opcode_n;
  logic [7:0]              texnum_n;
  logic [NUM_VERTS*32-1:0] verts_n;
  logic [31:0]             color_n;
  logic                    bad_n;

  assign head      = mem[rd_ptr];
  assign empty     = (fifo_count == '0);
  assign fifo_full = (fifo_count == CW'(FIFO_DEPTH));
  // A full FIFO still takes a write when the parser frees a slot in the same cycle.
  assign push      = fifo_write && (!fifo_full || pop);
  assign cmd_valid = (state == PRESENT);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= fifo_write_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (!push && pop) fifo_count <= fifo_count - 1'b1;
      if (fifo_write && !push) overflow <= 1'b1;
    end
  end

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    last_n   = last;
    opcode_n = cmd_opcode;
    texnum_n = cmd_texnum;
    verts_n  = cmd_verts;
    color_n  = cmd_color;
    bad_n    = bad_opcode;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          opcode_n = head[31:28];
          texnum_n = head[7:0];
          verts_n  = '0;
          color_n  = '0;
          idx_n    = '0;
          case (head[31:28])
            4'd1: begin
              last_n  = 3'(NUM_VERTS - 1);
              state_n = ARGS;
            end
            4'd3: begin
              last_n  = '0;
              state_n = ARGS;
            end
            4'd2:    state_n = PRESENT;
            4'd0:    state_n = IDLE;
            default: bad_n = 1'b1;
          endcase
        end
      end
      ARGS: begin
        if (!empty) begin
          pop = 1'b1;
          if (cmd_opcode == 4'd1) begin
            for (int i = 0; i < NUM_VERTS; i++) begin
              if (idx == 3'(i)) verts_n[i*32 +: 32] = head;
            end
          end else begin
            color_n = head;
          end
          if (idx == last) state_n = PRESENT;
          else             idx_n   = idx + 1'b1;
        end
      end
      PRESENT: begin
        if (cmd_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      last       <= '0;
      cmd_opcode <= '0;
      cmd_texnum <= '0;
      cmd_verts  <= '0;
      cmd_color  <= '0;
      bad_opcode <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      last       <= last_n;
      cmd_opcode <= opcode_n;
      cmd_texnum <= texnum_n;
      cmd_verts  <= verts_n;
      cmd_color  <= color_n;
      bad_opcode <= bad_n;
    end
  end

endmodule

// File: tb/tb_gpu_cmd_parser.sv
// tb/tb_gpu_cmd_parser.sv - directed self-checking bench for gpu_cmd_parser
module tb_gpu_cmd_parser;

  localparam int DEPTH = 16;
  localparam int NV    = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       fifo_write_data;
  logic              fifo_write;
  logic              fifo_full;
  logic [4:0]        fifo_count;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_opcode;
  logic [7:0]        cmd_texnum;
  logic [NV*32-1:0]  cmd_verts;
  logic [31:0]       cmd_color;
  logic              overflow;
  logic              bad_opcode;

  int total = 0;
  int bad   = 0;

  gpu_cmd_parser #(.FIFO_DEPTH(DEPTH), .NUM_VERTS(NV), .COORD_W(16)) dut (
    .clk(clk), .reset(reset),
    .fifo_write_data(fifo_write_data), .fifo_write(fifo_write),
    .fifo_full(fifo_full), .fifo_count(fifo_count),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_texnum(cmd_texnum),
    .cmd_verts(cmd_verts), .cmd_color(cmd_color),
    .overflow(overflow), .bad_opcode(bad_opcode)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    fifo_write      = 1'b1;
    fifo_write_data = w;
    @(negedge clk);
    fifo_write      = 1'b0;
    fifo_write_data = '0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (cmd_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " valid"}, cmd_valid, 1'b1);
  endtask

  task automatic expect_cmd(input string tag, input logic [3:0] op, input logic [7:0] tex,
                            input logic [NV*32-1:0] v, input logic [31:0] col);
    wait_valid(tag);
    chk({tag, " opcode"}, cmd_opcode, op);
    chk({tag, " texnum"}, cmd_texnum, tex);
    chk({tag, " verts"},  cmd_verts,  v);
    chk({tag, " color"},  cmd_color,  col);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    chk({tag, " drop"}, cmd_valid, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " count"},    fifo_count, 0);
    chk({tag, " full"},     fifo_full,  0);
    chk({tag, " valid"},    cmd_valid,  0);
    chk({tag, " opcode"},   cmd_opcode, 0);
    chk({tag, " texnum"},   cmd_texnum, 0);
    chk({tag, " verts"},    cmd_verts,  0);
    chk({tag, " color"},    cmd_color,  0);
    chk({tag, " overflow"}, overflow,   0);
    chk({tag, " badop"},    bad_opcode, 0);
  endtask

  function automatic logic [31:0] vw(input int k, input int i);
    return 32'hA000_0000 | 32'(k << 8) | 32'(i);
  endfunction

  function automatic logic [NV*32-1:0] vset(input int k);
    return {vw(k, 2), vw(k, 1), vw(k, 0)};
  endfunction

  initial begin
    reset = 1'b0; fifo_write = 1'b0; fifo_write_data = '0; cmd_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b1;

    // basic draw with consumer ready
    cmd_ready = 1'b1;
    push(32'h1000_0001);
    push(32'h000A_000A);
    push(32'h000A_006E);
    push(32'h006E_000A);
    chk("t1 pre valid", cmd_valid, 1'b0);
    @(negedge clk);
    chk("t1 valid", cmd_valid, 1'b1);
    chk("t1 opcode", cmd_opcode, 4'd1);
    chk("t1 texnum", cmd_texnum, 8'd1);
    chk("t1 verts", cmd_verts, {32'h006E_000A, 32'h000A_006E, 32'h000A_000A});
    @(negedge clk);
    chk("t1 one pulse", cmd_valid, 1'b0);
    chk("t1 count", fifo_count, 0);
    cmd_ready = 1'b0;

    // back-pressure: draw held stable, eof follows only after the handshake
    push(32'h1000_0005);
    push(32'h1111_2222);
    push(32'h3333_4444);
    push(32'h5555_6666);
    push(32'h2000_0000);
    wait_valid("t2 draw");
    for (int i = 0; i < 10; i++) begin
      chk("t2 hold valid", cmd_valid, 1'b1);
      chk("t2 hold verts", cmd_verts, {32'h5555_6666, 32'h3333_4444, 32'h1111_2222});
      chk("t2 hold tex", cmd_texnum, 8'd5);
      chk("t2 hold count", fifo_count, 1);
      @(negedge clk);
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    chk("t2 gap", cmd_valid, 1'b0);
    expect_cmd("t2 eof", 4'd2, 8'd0, '0, '0);

    // overflow while consumer stalls on an eof
    push(32'h2000_0000);
    wait_valid("t3 stall");
    for (int k = 0; k < 4; k++) begin
      push(32'h1000_0010 + 32'(k));
      for (int i = 0; i < NV; i++) push(vw(k, i));
    end
    chk("t3 count16", fifo_count, DEPTH);
    chk("t3 full", fifo_full, 1'b1);
    chk("t3 no ovf yet", overflow, 1'b0);
    push(32'h3000_0009);
    chk("t3 overflow", overflow, 1'b1);
    chk("t3 count kept", fifo_count, DEPTH);
    expect_cmd("t3 eof", 4'd2, 8'd0, '0, '0);
    for (int k = 0; k < 4; k++) expect_cmd("t3 draw", 4'd1, 8'h10 + 8'(k), vset(k), '0);
    repeat (3) @(negedge clk);
    chk("t3 drained", fifo_count, 0);
    chk("t3 no extra", cmd_valid, 1'b0);

    // unknown opcode then clear
    chk("t4 badop pre", bad_opcode, 1'b0);
    push(32'h7000_0000);
    push(32'h3000_0007);
    push(32'hFF00_00FF);
    expect_cmd("t4 clear", 4'd3, 8'd7, '0, 32'hFF00_00FF);
    chk("t4 badop", bad_opcode, 1'b1);

    // stalled arguments
    push(32'h1000_0022);
    for (int i = 0; i < NV; i++) begin
      repeat (5) begin
        @(negedge clk);
        chk("t5 stall", cmd_valid, 1'b0);
      end
      push(vw(9, i));
    end
    chk("t5 not yet", cmd_valid, 1'b0);
    @(negedge clk);
    chk("t5 one later", cmd_valid, 1'b1);
    expect_cmd("t5 draw", 4'd1, 8'h22, vset(9), '0);

    // reset in the middle of ARGS
    chk("t5r ovf sticky", overflow, 1'b1);
    push(32'h1000_0033);
    push(vw(5, 0));
    push(vw(5, 1));
    reset = 1'b0;
    #1;
    chk_all_zero("t5r async");
    @(negedge clk);
    reset = 1'b1;
    push(32'h3000_0044);
    push(32'h1234_5678);
    expect_cmd("t5r clear", 4'd3, 8'h44, '0, 32'h1234_5678);
    chk("t5r count", fifo_count, 0);

    // write accepted into a full FIFO on a pop cycle
    push(32'h2000_0000);
    wait_valid("t6 stall");
    for (int k = 4; k < 8; k++) begin
      push(32'h1000_0010 + 32'(k));
      for (int i = 0; i < NV; i++) push(vw(k, i));
    end
    chk("t6 full", fifo_full, 1'b1);
    cmd_ready = 1'b1;
    @(negedge clk);
    chk("t6 idle full", fifo_count, DEPTH);
    push(32'h2000_00AB);
    cmd_ready = 1'b0;
    chk("t6 count same", fifo_count, DEPTH);
    chk("t6 no ovf", overflow, 1'b0);
    for (int k = 4; k < 8; k++) expect_cmd("t6 draw", 4'd1, 8'h10 + 8'(k), vset(k), '0);
    expect_cmd("t6 eof", 4'd2, 8'hAB, '0, '0);
    chk("t6 count end", fifo_count, 0);
    chk("t6 ovf end", overflow, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpu_cmd_parser.md
Name: gpu_cmd_parser

Overview:
- Front end of the GPU command path: buffers 32-bit words from the host command write port in a parametrised FIFO.
- Parses them into complete draw, clear and end-of-frame packets, and presents each packet as one wide command to the rasteriser over a valid/ready handshake.
- Generalises the fixed triangle/end-op stream to N-vertex primitives and adds a clear opcode, overflow detection and bad-opcode reporting.

Parameters:
FIFO_DEPTH, 16, command FIFO entries; power of two, >=4
NUM_VERTS, 3, vertex words following a draw header (1..8)
COORD_W, 16, bits per x and per y coordinate; vertex word = {x[2*COORD_W-1:COORD_W], y[COORD_W-1:0]}, 2*COORD_W <= 32

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
fifo_write_data  in  32  command word from host
fifo_write  in  1  one-cycle write strobe; one word per asserted cycle
fifo_full  out  1  FIFO holds FIFO_DEPTH words
fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
cmd_valid  out  1  decoded command available
cmd_ready  in  1  consumer accepts command
cmd_opcode  out  4  1=draw, 2=end-of-frame, 3=clear
cmd_texnum  out  8  texture number from header [7:0]
cmd_verts  out  NUM_VERTS*32  vertex i at [32i+31:32i], raw words
cmd_color  out  32  {r,g,b,a} for clear; 0 otherwise
overflow  out  1  sticky: a write was dropped
bad_opcode  out  1  sticky: unknown header seen

Behaviour:
- Reset (reset=0, async): FIFO empty, fifo_count=0, fifo_full=0, FSM IDLE, cmd_valid=0, all cmd_* fields 0, overflow=0, bad_opcode=0. Reset mid-packet discards partial packet and all buffered words.
- Header word: {opcode[31:28], 20'b0, texnum[7:0]}; bits [27:8] ignored.
- FIFO: show-ahead; head word visible when count>0. A write is accepted if count<FIFO_DEPTH, or if count==FIFO_DEPTH and the parser pops in the same cycle. Otherwise the word is dropped and overflow set. Simultaneous accepted write and pop leave count unchanged. Pointers wrap modulo FIFO_DEPTH.
- A written word is poppable the cycle after its write edge.
- FSM states: IDLE, ARGS, PRESENT.
- IDLE: if FIFO non-empty, pop header, latch opcode/texnum, clear cmd_verts/cmd_color, then:
  - opcode 1: ARGS with nargs=NUM_VERTS.
  - opcode 3: ARGS with nargs=1.
  - opcode 2: PRESENT directly.
  - opcode 0: NOP; discard, stay IDLE.
  - opcode 4..15: set bad_opcode, discard, stay IDLE.
- ARGS: each cycle with FIFO non-empty, pop one word into slot idx (idx 0..nargs-1). Draw stores to cmd_verts slot idx; clear stores to cmd_color. Empty FIFO stalls with no timeout. After the last argument, go to PRESENT.
- PRESENT: cmd_valid=1 registered; all cmd_* fields stable while cmd_valid=1 and cmd_ready=0. On the cycle cmd_valid=1 and cmd_ready=1, the command transfers and the next state is IDLE with cmd_valid=0 next cycle. No popping in PRESENT.
- Throughput: a pre-buffered draw packet takes header cycle c, args c+1..c+NUM_VERTS, cmd_valid high at c+NUM_VERTS+1. With cmd_ready held high, back-to-back draws take NUM_VERTS+2 cycles each. End-of-frame takes 2 cycles; clear takes 3 cycles.
- cmd_ready while cmd_valid=0 has no effect.
- Sticky flags cleared only by reset.

Test Plan:
- Reset, write draw {4'd1,20'b0,8'd1}, 0x000A000A, 0x000A006E, 0x006E000A, cmd_ready=1 → one cmd_valid pulse; opcode=1, texnum=1, cmd_verts=={0x006E000A,0x000A006E,0x000A000A}; fifo_count returns to 0.
- Write draw then {4'd2,28'b0} with cmd_ready=0 for 10 cycles → first command held stable; end-of-frame presented only after cmd_ready pulses, opcode=2, verts=0.
- Write FIFO_DEPTH+1 words with consumer stalled in PRESENT → fifo_full=1 at count 16; the 17th word is dropped and overflow=1; later words still parse correctly.
- Write header 0x70000000, then clear {4'd3,...} + 0xFF0000FF → bad_opcode=1, no command for the bad header; clear presented with cmd_color=0xFF0000FF.
- Feed draw words with 5-cycle gaps between each → FSM stalls in ARGS; cmd_valid asserts exactly 1 cycle after the last vertex is poppable. Assert reset=0 mid-ARGS in a repeat run → all outputs 0 immediately; the next packet parses cleanly.
- With FIFO full and cmd_ready=1, write during a pop cycle → write accepted, count unchanged, overflow stays 0.
